oddr_tx_ctrl: RTL
=================

ODDR_TX_CTRL -- requirements
Module: oddr_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the parallel word width; legal values are even and at least 2.
REQ-002 The block SHALL have parameter GAP_CYC, default 0, meaning the number of idle clock cycles inserted between consecutive words; legal range is 0 to 255.
REQ-003 The block SHALL have parameter IDLE_LVL, default 1'b0, meaning the line level driven while no word is being sent.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic SHALL be on posedge clk.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port s_data, input, DATA_W bits: the word to transmit.
REQ-007 Port s_valid, input, 1 bit: s_data is valid.
REQ-008 Port s_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 Port dout, output, 1 bit: the DDR data pin, driven by an ODDR primitive.
REQ-010 Port frame, output, 1 bit: the DDR frame pin, driven by a second ODDR primitive with D1 = D2; it is high while word bits are on dout.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port d1_q, output, 1 bit: the registered rising-edge bit fed to the data ODDR; used for verification.
REQ-013 Port d2_q, output, 1 bit: the registered falling-edge bit fed to the data ODDR; used for verification.
REQ-014 Port word_cnt, output, 16 bits: the number of words accepted, wrapping modulo 2^16.

Function
REQ-015 The block SHALL implement the states IDLE, SHIFT and GAP.
REQ-016 A word SHALL be accepted on any rising edge where s_valid and s_ready are both high.
REQ-017 s_ready SHALL be high in IDLE, in the last SHIFT cycle when GAP_CYC = 0, and in the last GAP cycle; it SHALL be low in every other cycle and while rst is high.
REQ-018 On acceptance, the block SHALL load a shift register and set d1_q = s_data[DATA_W-1] and d2_q = s_data[DATA_W-2] on that same edge.
REQ-019 The block SHALL then present the next bit pair, MSB-first, on each following edge, for a total of DATA_W/2 SHIFT cycles per word.
REQ-020 Both ODDR primitives SHALL be configured with DDR_CLK_EDGE "SAME_EDGE", SRTYPE "ASYNC", INIT 0, CE 1 and R tied to rst.
REQ-021 Pin timing is fixed by the ODDR register: d1_q appears on dout in the clock-high half of the next cycle, and d2_q appears in the clock-low half of that cycle.
REQ-022 The registered frame value SHALL be 1 exactly during SHIFT cycles and 0 otherwise.
REQ-023 Transitions from SHIFT: after the last pair, the state SHALL go to GAP if GAP_CYC > 0.
REQ-024 Transitions from SHIFT: after the last pair, with GAP_CYC = 0, the state SHALL stay in SHIFT if a new word is accepted and go to IDLE otherwise.
REQ-025 GAP SHALL last exactly GAP_CYC cycles with d1_q = d2_q = IDLE_LVL and frame = 0.
REQ-026 On leaving GAP, the state SHALL go to SHIFT if a word is accepted in the last GAP cycle and to IDLE otherwise.
REQ-027 Changes on s_data or s_valid while s_ready is low SHALL be ignored; the shift register SHALL hold its captured copy.
REQ-028 When GAP_CYC = 0 with back-to-back acceptance, the block SHALL stream continuously with no idle half-cycles.
REQ-029 When DATA_W = 2, SHIFT SHALL last 1 cycle, and s_ready SHALL stay high for continuous streaming if GAP_CYC = 0.
REQ-030 word_cnt SHALL increment by 1 per accepted word and wrap from 16'hFFFF to 16'h0000.
REQ-031 The pair counter and the gap counter SHALL be sized by $clog2 of DATA_W/2 and GAP_CYC (minimum 1 bit) and SHALL never exceed their terminal values.

Reset
REQ-032 While rst is high, the block SHALL immediately force state = IDLE, d1_q = d2_q = IDLE_LVL, frame = 0, busy = 0, word_cnt = 0, s_ready = 0, and clear both counters and the shift register.
REQ-033 An assertion of rst mid-word SHALL abort the word with no partial resume after release.
REQ-034 On the first cycle after rst deasserts, s_ready SHALL be 1.
REQ-035 The ODDR outputs SHALL go to 0 asynchronously while rst is high.

Verification
REQ-036 Single word, DATA_W=8, GAP_CYC=0: accept 8'hA5 -> (d1_q,d2_q) = (1,0),(1,0),(0,1),(0,1) on 4 consecutive edges, frame high for 4 cycles, dout at the pin = 1,0,1,0,0,1,0,1 per half-cycle, then IDLE_LVL; word_cnt = 1.
REQ-037 Back-to-back, GAP_CYC=0: s_valid held high with 8'hFF then 8'h00 -> s_ready high in cycles 4 and 8, frame high for 8 cycles with no gap, 16 contiguous bits on dout.
REQ-038 Gap, GAP_CYC=3: two words queued -> 4 SHIFT cycles, 3 cycles with frame=0 and IDLE_LVL on the pins, 4 SHIFT cycles; s_ready high only in the 3rd gap cycle.
REQ-039 Backpressure: s_data toggles while s_ready is low -> the transmitted bits match the word captured at acceptance.
REQ-040 Reset mid-word: rst pulse after the 2nd pair -> outputs at reset values immediately, no further word bits, s_ready=1 in the cycle after release, word_cnt=0.
REQ-041 Wrap: accept 65536 words (DATA_W=2, GAP_CYC=0) -> word_cnt returns to 0, frame stays continuously high, s_ready stays high.

Source files
------------

// File: rtl/oddr_tx_ctrl.sv
// DDR serialiser: streams DATA_W-bit words MSB-first, two bits per clock, through ODDR cells.
// Latency: a word accepted on edge N drives its first pair at the pins in the cycle after edge N+1.
// Backpressure: s_ready is high only in IDLE, the last SHIFT cycle (GAP_CYC = 0) or the last GAP cycle.

// Behavioural ODDR cell, same-edge capture with async reset.
// Both bits are captured on the rising edge; Q shows D1 while clock is high, D2 while it is low.
// Reset clears both capture registers immediately, so the pin goes to 0 as soon as i_r rises.
module oddr_tx_ctrl_oddr #(
  parameter logic INIT = 1'b0
) (
  output logic o_q,
  input  logic i_c,
  input  logic i_ce,
  input  logic i_d1,
  input  logic i_d2,
  input  logic i_r
);

  logic r_q1;
  logic r_q2;

  // Capture both halves of the next output cycle on the rising edge.
  always_ff @(posedge i_c or posedge i_r) begin
    if (i_r) begin
      r_q1 <= INIT;
      r_q2 <= INIT;
    end else if (i_ce) begin
      r_q1 <= i_d1;
      r_q2 <= i_d2;
    end
  end

  assign o_q = i_c ? r_q1 : r_q2;

endmodule

module oddr_tx_ctrl #(
  parameter int   DATA_W   = 8,
  parameter int   GAP_CYC  = 0,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dout,
  output logic              frame,
  output logic              busy,
  output logic              d1_q,
  output logic              d2_q,
  output logic [15:0]       word_cnt
);

  localparam int PAIRS  = DATA_W / 2;
  localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(PAIRS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [PAIR_W-1:0]   r_pair_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [DATA_W-1:0]   r_sreg;
  logic                r_d1;
  logic                r_d2;
  logic                r_frame;
  logic [15:0]         r_word_cnt;

  logic w_last_pair;
  logic w_last_gap;
  logic w_ready;
  logic w_accept;

  assign w_last_pair = (r_state == ST_SHIFT) && (r_pair_cnt == PAIR_LAST);
  assign w_last_gap  = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
  // A new word may only land where it can start shifting on the very next edge.
  assign w_ready     = !rst && ((r_state == ST_IDLE) ||
                                (w_last_pair && (GAP_CYC == 0)) ||
                                w_last_gap);
  assign w_accept    = w_ready && s_valid;

  // Control FSM: every acceptance point reloads the shifter, so acceptance takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pair_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sreg     <= '0;
      r_d1       <= IDLE_LVL;
      r_d2       <= IDLE_LVL;
      r_frame    <= 1'b0;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_state    <= ST_SHIFT;
      r_pair_cnt <= '0;
      r_gap_cnt  <= '0;
      r_d1       <= s_data[DATA_W-1];
      r_d2       <= s_data[DATA_W-2];
      r_sreg     <= s_data << 2;
      r_frame    <= 1'b1;
      r_word_cnt <= r_word_cnt + 16'd1;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (!w_last_pair) begin
            r_d1       <= r_sreg[DATA_W-1];
            r_d2       <= r_sreg[DATA_W-2];
            r_sreg     <= r_sreg << 2;
            r_pair_cnt <= r_pair_cnt + PAIR_W'(1);
          end else begin
            r_state    <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            r_pair_cnt <= '0;
            r_gap_cnt  <= '0;
            r_d1       <= IDLE_LVL;
            r_d2       <= IDLE_LVL;
            r_frame    <= 1'b0;
          end
        end
        ST_GAP: begin
          if (!w_last_gap) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end else begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_d1    <= IDLE_LVL;
          r_d2    <= IDLE_LVL;
          r_frame <= 1'b0;
        end
      endcase
    end
  end

  oddr_tx_ctrl_oddr #(.INIT(1'b0)) u_oddr_data (
    .o_q  (dout),
    .i_c  (clk),
    .i_ce (1'b1),
    .i_d1 (r_d1),
    .i_d2 (r_d2),
    .i_r  (rst)
  );

  oddr_tx_ctrl_oddr #(.INIT(1'b0)) u_oddr_frame (
    .o_q  (frame),
    .i_c  (clk),
    .i_ce (1'b1),
    .i_d1 (r_frame),
    .i_d2 (r_frame),
    .i_r  (rst)
  );

  assign s_ready  = w_ready;
  assign busy     = (r_state != ST_IDLE);
  assign d1_q     = r_d1;
  assign d2_q     = r_d2;
  assign word_cnt = r_word_cnt;

endmodule
